// File: rtl/unpack_pkt_arbiter.sv
// Packet-level round-robin arbiter that feeds one shared data_unpack from NUM_CH sources.
// A whole packet (sop..eop) is locked to one channel; stray non-sop words are drained while idle.
module unpack_pkt_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int DROP_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH*32-1:0] req_data,
  input  logic [NUM_CH-1:0]    req_sop,
  input  logic [NUM_CH-1:0]    req_eop,
  output logic [NUM_CH-1:0]    req_ready,
  output logic                 up_valid,
  output logic [31:0]          up_data,
  output logic                 up_sop,
  output logic                 up_eop,
  input  logic                 up_ready,
  output logic [CH_W-1:0]      grant_ch,
  output logic                 busy,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic                 sop_err
);

  // Handshake: a word moves on a port in any cycle where its valid and ready are both 1.
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t              r_state, w_state_nxt;
  logic [CH_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [CH_W-1:0]     r_grant_ch, w_grant_nxt;
  logic [DROP_W-1:0]   r_drop_cnt, w_drop_nxt;
  logic                r_sop_err, w_sop_err_nxt;

  logic                w_found;
  logic [CH_W-1:0]     w_win;
  logic [CH_W-1:0]     w_probe;
  logic [CH_W-1:0]     w_sel;
  logic                w_sel_act;
  logic [NUM_CH-1:0]   w_drain;
  logic [CH_W:0]       w_drain_n;
  logic [DROP_W:0]     w_drop_sum;
  logic                w_xfer;

  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] c);
    return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  // Round-robin search for a sop candidate starting at the pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_probe = r_rr_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_found && req_valid[w_probe] && req_sop[w_probe]) begin
        w_found = 1'b1;
        w_win   = w_probe;
      end
      w_probe = wrap_inc(w_probe);
    end
  end

  assign w_sel     = (r_state == ST_LOCKED) ? r_grant_ch : w_win;
  assign w_sel_act = (r_state == ST_LOCKED) || w_found;

  assign up_data  = req_data[32*w_sel +: 32];
  assign up_sop   = w_sel_act && req_sop[w_sel];
  assign up_eop   = w_sel_act && req_eop[w_sel];
  assign up_valid = !rst && w_sel_act && req_valid[w_sel];
  assign w_xfer   = up_valid && up_ready;

  // Draining only happens while idle and only when the unpacker would accept a word.
  always_comb begin
    w_drain   = '0;
    w_drain_n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst && r_state == ST_IDLE && up_ready && req_valid[i] && !req_sop[i] &&
          !(w_found && w_win == CH_W'(i))) begin
        w_drain[i] = 1'b1;
      end
      w_drain_n = w_drain_n + (CH_W+1)'(w_drain[i]);
    end
  end

  always_comb begin
    req_ready = w_drain;
    if (!rst && w_sel_act) req_ready[w_sel] = up_ready;
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_W+1)'(w_drain_n);
  assign w_drop_nxt = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_grant_nxt   = r_grant_ch;
    w_sop_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_grant_nxt = w_win;
          if (up_eop) w_rr_ptr_nxt = wrap_inc(w_win);
          else        w_state_nxt  = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_xfer) begin
          w_sop_err_nxt = up_sop;
          if (up_eop) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = wrap_inc(r_grant_ch);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_ch <= '0;
      r_drop_cnt <= '0;
      r_sop_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_ch <= w_grant_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_sop_err  <= w_sop_err_nxt;
    end
  end

  assign grant_ch = r_grant_ch;
  assign busy     = (r_state == ST_LOCKED);
  assign drop_cnt = r_drop_cnt;
  assign sop_err  = r_sop_err;

endmodule

// File: tb/tb_unpack_pkt_arbiter.sv
// Bench for unpack_pkt_arbiter: directed vector table, hand sequences and random traffic,
// all checked every cycle against a packet-level reference model.
module tb_unpack_pkt_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid, req_sop, req_eop, req_ready;
  logic [N*32-1:0] req_data;
  logic         up_valid, up_sop, up_eop, up_ready;
  logic [31:0]  up_data;
  logic [1:0]   grant_ch;
  logic         busy, sop_err;
  logic [15:0]  drop_cnt;

  unpack_pkt_arbiter #(.NUM_CH(N), .DROP_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_sop(req_sop), .req_eop(req_eop),
    .req_ready(req_ready),
    .up_valid(up_valid), .up_data(up_data), .up_sop(up_sop), .up_eop(up_eop),
    .up_ready(up_ready),
    .grant_ch(grant_ch), .busy(busy), .drop_cnt(drop_cnt), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
  } word_t;

  typedef struct {
    logic [3:0] v, s, e;
    bit         ur;
    bit         uv;
    logic [3:0] rdy;
    bit         bsy;
    logic [1:0] gr;
    int         drop;
  } vec_t;

  int n_vec, n_err;

  // reference model state
  bit   m_locked, m_sop_err;
  int   m_grant, m_ptr, m_drop;
  logic [3:0] e_rdy;
  bit   e_uv;
  int   e_sel;
  logic [3:0] c_v, c_s, c_e;
  bit   c_ur, c_rb;
  int   glog[$];
  word_t chq[N][$];

  // DUT samples from the most recent check point
  logic [3:0] s_rdy;
  logic       s_busy, s_sop_err;
  logic [15:0] s_drop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_sop_err = 0; m_grant = 0; m_ptr = 0; m_drop = 0;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; req_sop = '0; req_eop = '0; req_data = '0; up_ready = 0;
    repeat (2) @(posedge clk);
    model_reset();
    for (int i = 0; i < N; i++) chq[i].delete();
    glog.delete();
  endtask

  task automatic drive_and_check(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                                 input logic [N*32-1:0] d, input bit ur, input bit rb);
    @(negedge clk);
    req_valid = v; req_sop = s; req_eop = e; req_data = d; up_ready = ur; rst = rb;
    c_v = v; c_s = s; c_e = e; c_ur = ur; c_rb = rb;
    #1;
    e_rdy = '0; e_uv = 0; e_sel = -1;
    if (!rb) begin
      if (m_locked) e_sel = m_grant;
      else
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (e_sel < 0 && v[c] && s[c]) e_sel = c;
        end
      if (e_sel >= 0) begin
        e_uv = v[e_sel];
        e_rdy[e_sel] = ur;
      end
      if (!m_locked && ur)
        for (int i = 0; i < N; i++) if (v[i] && !s[i]) e_rdy[i] = 1'b1;
    end
    chk("req_ready", req_ready, e_rdy);
    chk("up_valid", up_valid, e_uv);
    if (e_uv) begin
      chk("up_data", up_data, d[32*e_sel +: 32]);
      chk("up_sop", up_sop, s[e_sel]);
      chk("up_eop", up_eop, e[e_sel]);
    end
    chk("grant_ch", grant_ch, m_grant);
    chk("busy", busy, m_locked);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("sop_err", sop_err, m_sop_err);
    s_rdy = req_ready; s_busy = busy; s_drop = drop_cnt; s_sop_err = sop_err;
  endtask

  task automatic commit();
    bit xfer;
    int ndrop;
    @(posedge clk);
    xfer  = e_uv && c_ur;
    ndrop = 0;
    for (int i = 0; i < N; i++) if (i != e_sel && e_rdy[i] && c_v[i]) ndrop++;
    if (c_rb) model_reset();
    else begin
      m_sop_err = m_locked && xfer && c_s[e_sel];
      if (xfer) begin
        if (!m_locked) begin
          glog.push_back(e_sel);
          m_grant = e_sel;
          if (c_e[e_sel]) m_ptr = (e_sel + 1) % N;
          else m_locked = 1;
        end else if (c_e[e_sel]) begin
          m_locked = 0;
          m_ptr = (m_grant + 1) % N;
        end
      end
      m_drop = (m_drop + ndrop > 65535) ? 65535 : m_drop + ndrop;
    end
  endtask

  task automatic qcycle(input logic [3:0] pres, input bit ur, input bit rb);
    logic [3:0] v, s, e;
    logic [N*32-1:0] d;
    v = '0; s = '0; e = '0;
    for (int i = 0; i < N; i++) begin
      d[32*i +: 32] = $urandom;
      if (chq[i].size() > 0 && pres[i]) begin
        v[i] = 1'b1; s[i] = chq[i][0].s; e[i] = chq[i][0].e; d[32*i +: 32] = chq[i][0].d;
      end
    end
    drive_and_check(v, s, e, d, ur, rb);
    commit();
    for (int i = 0; i < N; i++) if (v[i] && e_rdy[i]) void'(chq[i].pop_front());
  endtask

  task automatic push_pkt(input int ch, input int len);
    for (int j = 0; j < len; j++)
      chq[ch].push_back('{d: $urandom, s: (j == 0), e: (j == len - 1)});
  endtask

  task automatic push_stray(input int ch, input int cnt);
    for (int j = 0; j < cnt; j++) chq[ch].push_back('{d: $urandom, s: 1'b0, e: 1'b0});
  endtask

  vec_t tbl[10];

  initial begin
    int cnt;
    logic [N*32-1:0] rd;
    n_vec = 0; n_err = 0;

    tbl[0] = '{4'b0100, 4'b0100, 4'b0000, 1, 1, 4'b0100, 0, 2'd0, 0};
    tbl[1] = '{4'b0100, 4'b0000, 4'b0000, 1, 1, 4'b0100, 1, 2'd2, 0};
    tbl[2] = '{4'b0100, 4'b0000, 4'b0100, 1, 1, 4'b0100, 1, 2'd2, 0};
    tbl[3] = '{4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd2, 0};
    tbl[4] = '{4'b1001, 4'b1001, 4'b1001, 1, 1, 4'b1000, 0, 2'd2, 0};
    tbl[5] = '{4'b0001, 4'b0001, 4'b0001, 1, 1, 4'b0001, 0, 2'd3, 0};
    tbl[6] = '{4'b0010, 4'b0000, 4'b0000, 1, 0, 4'b0010, 0, 2'd0, 0};
    tbl[7] = '{4'b0110, 4'b0100, 4'b0100, 1, 1, 4'b0110, 0, 2'd0, 1};
    tbl[8] = '{4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd2, 2};
    tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd2, 2};

    // directed table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      drive_and_check(tbl[i].v, tbl[i].s, tbl[i].e, rd, tbl[i].ur, 0);
      chk($sformatf("tbl%0d_up_valid", i), up_valid, tbl[i].uv);
      chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_grant", i), grant_ch, tbl[i].gr);
      chk($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].drop);
      commit();
    end

    // fairness with all channels streaming 2-word packets
    do_reset();
    for (int i = 0; i < N; i++) for (int p = 0; p < 3; p++) push_pkt(i, 2);
    for (int c = 0; c < 24; c++) qcycle(4'hF, 1, 0);
    chk("rr_grant_count", glog.size(), 12);
    for (int j = 0; j < glog.size() && j < 12; j++) chk($sformatf("rr_grant%0d", j), glog[j], j % N);

    // stray words drained, then a packet on the same channel
    do_reset();
    push_stray(1, 5);
    push_pkt(1, 3);
    for (int c = 0; c < 8; c++) qcycle(4'hF, 1, 0);
    chk("drain_drop_cnt", s_drop, 5);
    chk("drain_grant_count", glog.size(), 1);

    // back-pressure while locked on ch0, ch3 pending
    do_reset();
    push_pkt(0, 3);
    push_pkt(3, 2);
    qcycle(4'hF, 1, 0);
    qcycle(4'hF, 1, 0);
    qcycle(4'hF, 0, 0);
    qcycle(4'hF, 0, 0);
    qcycle(4'hF, 1, 0);
    qcycle(4'hF, 1, 0);
    chk("bp_ch3_ready", s_rdy, 4'b1000);
    qcycle(4'hF, 1, 0);
    chk("bp_ch3_busy", s_busy, 1);
    chk("bp_grant_order", glog.size(), 2);

    // sop in the middle of a locked packet
    do_reset();
    chq[1].push_back('{d: $urandom, s: 1'b1, e: 1'b0});
    chq[1].push_back('{d: $urandom, s: 1'b0, e: 1'b0});
    chq[1].push_back('{d: $urandom, s: 1'b1, e: 1'b0});
    chq[1].push_back('{d: $urandom, s: 1'b0, e: 1'b1});
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      qcycle(4'hF, 1, 0);
      if (s_sop_err) cnt++;
    end
    chk("sop_err_pulses", cnt, 1);
    chk("sop_err_grant_count", glog.size(), 1);

    // reset in the middle of a packet
    do_reset();
    push_stray(0, 2);
    push_pkt(2, 4);
    qcycle(4'hF, 1, 0);
    qcycle(4'hF, 1, 0);
    qcycle(4'hF, 1, 1);
    chk("rst_ready", s_rdy, 4'b0000);
    for (int i = 0; i < N; i++) begin
      chq[i].delete();
      push_pkt(i, 1);
    end
    glog.delete();
    qcycle(4'hF, 1, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_drop", s_drop, 0);
    for (int c = 0; c < 3; c++) qcycle(4'hF, 1, 0);
    chk("rst_grant_count", glog.size(), 4);
    for (int j = 0; j < glog.size() && j < 4; j++) chk($sformatf("rst_grant%0d", j), glog[j], j);

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] pres;
      for (int i = 0; i < N; i++) begin
        if (chq[i].size() < 2) begin
          if ($urandom_range(0, 9) < 2) push_stray(i, 1);
          else begin
            int len;
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++)
              chq[i].push_back('{d: $urandom, s: (j == 0) || ($urandom_range(0, 15) == 0),
                                 e: (j == len - 1)});
          end
        end
        pres[i] = ($urandom_range(0, 3) != 0);
      end
      qcycle(pres, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    end

    // drop counter saturation: four drains per cycle
    do_reset();
    for (int c = 0; c < 16390; c++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      drive_and_check(4'hF, 4'h0, 4'h0, rd, 1, 0);
      commit();
    end
    drive_and_check(4'h0, 4'h0, 4'h0, '0, 1, 0);
    chk("drop_saturate", drop_cnt, 16'hFFFF);
    commit();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unpack_pkt_arbiter.md
Name: unpack_pkt_arbiter

Overview:
Packet-level round-robin arbiter that shares one data_unpack instance between NUM_CH independent 32-bit packet sources. It grants a whole packet, sop through eop, to a single channel. It locks the unpacker input to that channel until the eop word transfers, then re-arbitrates. Words a channel presents outside a packet are drained and counted, so no channel can stall the shared unpacker.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
CH_W, $clog2(NUM_CH), width of channel index
DROP_W, 16, width of the saturating drop counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_CH  per-channel word valid
req_data  in  NUM_CH*32  per-channel data word; channel i occupies bits [32*i+31:32*i]
req_sop  in  NUM_CH  per-channel first word of packet
req_eop  in  NUM_CH  per-channel last word of packet
req_ready  out  NUM_CH  per-channel accept; a word transfers when req_valid[i] and req_ready[i] are both 1
up_valid  out  1  to unpacker valid_in
up_data  out  32  to unpacker data_in
up_sop  out  1  to unpacker sop_in
up_eop  out  1  to unpacker eop_in
up_ready  in  1  from unpacker ready_out
grant_ch  out  CH_W  channel currently locked, or last granted channel
busy  out  1  1 while in LOCKED
drop_cnt  out  DROP_W  words discarded outside packets; saturates at all-ones
sop_err  out  1  one-cycle pulse when a sop word is accepted on the granted channel while LOCKED

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant_ch=0, busy=0, drop_cnt=0, sop_err=0.
- While rst=1: req_ready=0 and up_valid=0 (forced combinationally).
- Forwarding path: the data mux is combinational, zero cycles from req_* to up_*. up_data, up_sop and up_eop come from the selected channel. Only state, pointer and counters are registered.
- Handshake: the selected channel's req_ready equals up_ready. up_valid equals the selected channel's req_valid. No other channel sees req_ready=1, except for draining (below).
- State IDLE:
  - Candidates are channels with req_valid & req_sop.
  - Winner is the first candidate found searching rr_ptr, rr_ptr+1, ... modulo NUM_CH. The winner is forwarded in the same cycle.
  - Winner transfers with eop=0: go to LOCKED, grant_ch<=winner.
  - Winner transfers with eop=1 (single-word packet): stay in IDLE, grant_ch<=winner, rr_ptr<=winner+1 mod NUM_CH.
  - No candidate: up_valid=0.
  - Drain: any non-winner channel with req_valid=1 and req_sop=0 gets req_ready=1. Its word is dropped and drop_cnt increments. Several drains in one cycle add their count, saturating at all-ones.
  - Candidates that lose arbitration get req_ready=0 and hold their word.
- State LOCKED:
  - Only grant_ch is forwarded. All other channels get req_ready=0; no draining of other channels while LOCKED.
  - Transfer with eop=1: go to IDLE, rr_ptr<=grant_ch+1 mod NUM_CH.
  - Transfer with sop=1: the word is forwarded unchanged and sop_err pulses for 1 cycle. The arbiter stays LOCKED (a new packet on the same channel). If that word also has eop=1, the eop rule applies.
  - req_valid=0 on the granted channel: up_valid=0 and the arbiter holds the lock indefinitely (no timeout).
- Back-pressure: up_ready=0 blocks every transfer. No state, pointer or counter changes; no drain occurs in that cycle (drain is gated by up_ready so accepted-word order stays simple).
- Wrap-around: the rr_ptr increment wraps at NUM_CH-1 to 0. grant_ch holds its value after returning to IDLE.
- Fairness: with all channels continuously requesting, grants rotate 0,1,2,...,NUM_CH-1,0. A channel waits at most NUM_CH-1 packets.
- Throughput:
  - A sop word can be accepted in the cycle after an eop transfer. Zero dead cycles between packets when up_ready=1 and the next winner is already valid.
  - Back-to-back single-word packets sustain one per cycle.
- Reset mid-packet: the lock is abandoned immediately and state returns to IDLE. The unpacker is reset by the same rst.

Test Plan:
- Reset, then ch2 sends a 3-word packet (sop on word0, eop on word2) with up_ready=1 -> up_* mirrors ch2 for 3 cycles with zero latency; busy=1 from cycle 1 through the eop cycle; grant_ch=2; rr_ptr=3 afterward.
- All 4 channels hold 2-word packets continuously -> grant order 0,1,2,3,0; no idle cycle between packets; each channel's req_ready=1 only during its own packet.
- ch1 presents 5 non-sop words while IDLE, then a sop packet -> drop_cnt=5; the ch1 packet is then granted and forwarded intact.
- Locked on ch0 with up_ready toggled 1,0,0,1 -> words transfer only in up_ready=1 cycles; ch3's pending sop word stays held with req_ready[3]=0 until ch0's eop transfers, then ch3 is granted in the next cycle.
- While LOCKED on ch1, ch1 sends a sop word mid-packet -> sop_err pulses for exactly 1 cycle, the word is forwarded with up_sop=1, and the arbiter remains LOCKED on ch1.
- Assert rst for 1 cycle mid-packet on ch2 -> busy=0, drop_cnt=0, all req_ready=0 during rst; arbitration restarts from ch0.
